// File: rtl/clk_gate_seq.sv
// rtl/clk_gate_seq.sv - ICG enable sequencer with wake-up delay and idle hold-off
// Optional activity counter enabled by defining CLK_GATE_STAT_EN.
module clk_gate_seq #(
   parameter int NREQ     = 4,
   parameter int WAKE_CYC = 2,
   parameter int IDLE_CYC = 16,
   parameter int CNT_W    = 16
) (
   input  logic            CP,
   input  logic            CD,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] ack,
   input  logic            force_on,
   input  logic            scan_te,
   output logic            gate_e,
   output logic            gate_te,
   output logic            busy,
   output logic [1:0]      state
`ifdef CLK_GATE_STAT_EN
   ,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_cnt
`endif
);

   localparam int MAX_CYC = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYC - 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);

   typedef enum logic [1:0] {
      OFF  = 2'b00,
      WAKE = 2'b01,
      ON   = 2'b10,
      HOLD = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic            gate_e_q, gate_e_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [CW-1:0]   wake_cnt_q, wake_cnt_d;
   logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
   logic            any_req;

   always_comb begin
      any_req    = (|req) | force_on;
      state_d    = state_q;
      wake_cnt_d = '0;
      idle_cnt_d = '0;
      case (state_q)
         OFF: begin
            if (any_req) state_d = WAKE;
         end
         // No abort out of WAKE: the ICG enable never pulses shorter than WAKE_CYC.
         WAKE: begin
            if (wake_cnt_q == WAKE_LAST) state_d = ON;
            else wake_cnt_d = wake_cnt_q + 1'b1;
         end
         ON: begin
            if (!any_req) state_d = HOLD;
         end
         HOLD: begin
            if (any_req) state_d = ON;
            else if (idle_cnt_q == IDLE_LAST) state_d = OFF;
            else idle_cnt_d = idle_cnt_q + 1'b1;
         end
         default: state_d = OFF;
      endcase
      gate_e_d = (state_d != OFF);
      ack_d    = (state_d == ON) ? req : '0;
   end

   always_ff @(posedge CP or posedge CD) begin
      if (CD) begin
         state_q    <= OFF;
         gate_e_q   <= 1'b0;
         ack_q      <= '0;
         wake_cnt_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gate_e_q   <= gate_e_d;
         ack_q      <= ack_d;
         wake_cnt_q <= wake_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign ack     = ack_q;
   assign gate_e  = gate_e_q;
   assign gate_te = scan_te;
   assign busy    = (state_q != OFF);
   assign state   = state_q;

`ifdef CLK_GATE_STAT_EN
   logic [CNT_W-1:0] stat_cnt_q, stat_cnt_d;

   always_comb begin
      stat_cnt_d = stat_cnt_q;
      if (stat_clr) stat_cnt_d = '0;
      else if (gate_e_q && (stat_cnt_q != '1)) stat_cnt_d = stat_cnt_q + 1'b1;
   end

   always_ff @(posedge CP or posedge CD) begin
      if (CD) stat_cnt_q <= '0;
      else    stat_cnt_q <= stat_cnt_d;
   end

   assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_clk_gate_seq.sv
// tb/tb_clk_gate_seq.sv - directed table-driven bench for clk_gate_seq
module tb_clk_gate_seq;

   localparam logic [1:0] S_OFF  = 2'b00;
   localparam logic [1:0] S_WAKE = 2'b01;
   localparam logic [1:0] S_ON   = 2'b10;
   localparam logic [1:0] S_HOLD = 2'b11;

   logic       CP;
   logic       CD;
   logic [3:0] req;
   logic [3:0] ack;
   logic       force_on;
   logic       scan_te;
   logic       gate_e;
   logic       gate_te;
   logic       busy;
   logic [1:0] state;
`ifdef CLK_GATE_STAT_EN
   logic       stat_clr;
   logic [3:0] stat_cnt;
`endif

   int passed = 0;
   int total  = 0;

   clk_gate_seq #(
      .NREQ(4),
      .WAKE_CYC(2),
      .IDLE_CYC(16),
      .CNT_W(4)
   ) dut (
      .CP(CP),
      .CD(CD),
      .req(req),
      .ack(ack),
      .force_on(force_on),
      .scan_te(scan_te),
      .gate_e(gate_e),
      .gate_te(gate_te),
      .busy(busy),
      .state(state)
`ifdef CLK_GATE_STAT_EN
      ,
      .stat_clr(stat_clr),
      .stat_cnt(stat_cnt)
`endif
   );

   initial begin
      CP = 1'b0;
      forever #5 CP = ~CP;
   end

   typedef struct {
      logic [3:0] req;
      logic       force_on;
      logic       scan_te;
      logic [1:0] st;
      logic       ge;
      logic [3:0] ack;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [3:0] r, input logic f, input logic s,
                               input logic [1:0] st, input logic ge, input logic [3:0] a);
      vec_t v;
      v.req = r; v.force_on = f; v.scan_te = s; v.st = st; v.ge = ge; v.ack = a;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   task automatic chk_all(input string name, input logic [1:0] st, input logic ge, input logic [3:0] a);
      check({name, ".state"}, 32'(state), 32'(st));
      check({name, ".gate_e"}, 32'(gate_e), 32'(ge));
      check({name, ".ack"}, 32'(ack), 32'(a));
      check({name, ".busy"}, 32'(busy), 32'(st != S_OFF));
   endtask

   task automatic pulse_reset();
      @(negedge CP);
      CD = 1'b1;
      @(negedge CP);
      CD = 1'b0;
   endtask

   initial begin
      CD = 1'b1; req = '0; force_on = 1'b0; scan_te = 1'b0;
`ifdef CLK_GATE_STAT_EN
      stat_clr = 1'b0;
`endif
      #12;
      chk_all("reset", S_OFF, 1'b0, 4'b0000);
      @(negedge CP);
      CD = 1'b0;

      // req[0] wake-up, multi-requester ON, drop to HOLD and count out
      add(4'b0001, 0, 0, S_WAKE, 1, 4'b0000);
      add(4'b0001, 0, 1, S_WAKE, 1, 4'b0000);
      add(4'b0001, 0, 0, S_ON,   1, 4'b0001);
      add(4'b0011, 0, 0, S_ON,   1, 4'b0011);
      add(4'b0010, 0, 1, S_ON,   1, 4'b0010);
      add(4'b0000, 0, 0, S_HOLD, 1, 4'b0000);
      for (int i = 0; i < 15; i++) add(4'b0000, 0, 1'(i % 2), S_HOLD, 1, 4'b0000);
      add(4'b0000, 0, 0, S_OFF,  0, 4'b0000);
      add(4'b0000, 0, 1, S_OFF,  0, 4'b0000);
      // force_on behaves as a requester without ack
      add(4'b0000, 1, 0, S_WAKE, 1, 4'b0000);
      add(4'b0000, 1, 1, S_WAKE, 1, 4'b0000);
      add(4'b0000, 1, 0, S_ON,   1, 4'b0000);
      add(4'b0000, 1, 1, S_ON,   1, 4'b0000);
      add(4'b0000, 0, 0, S_HOLD, 1, 4'b0000);
      for (int i = 0; i < 15; i++) add(4'b0000, 0, 1'(i % 3 == 0), S_HOLD, 1, 4'b0000);
      add(4'b0000, 0, 0, S_OFF,  0, 4'b0000);

      for (int i = 0; i < vecs.size(); i++) begin
         req = vecs[i].req; force_on = vecs[i].force_on; scan_te = vecs[i].scan_te;
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ge, vecs[i].ack);
         check($sformatf("vec%0d.gate_te", i), 32'(gate_te), 32'(vecs[i].scan_te));
      end
      scan_te = 1'b0;

      // HOLD re-request at idle count 10 and at terminal count 15
      req = 4'b0100;
      repeat (3) tick();
      chk_all("h3.on", S_ON, 1'b1, 4'b0100);
      req = 4'b0000;
      tick();
      repeat (10) tick();
      chk_all("h3.hold10", S_HOLD, 1'b1, 4'b0000);
      req = 4'b0100;
      tick();
      chk_all("h3.rewake10", S_ON, 1'b1, 4'b0100);
      req = 4'b0000;
      tick();
      repeat (15) tick();
      chk_all("h3.hold15", S_HOLD, 1'b1, 4'b0000);
      req = 4'b0100;
      tick();
      chk_all("h3.terminal_wins", S_ON, 1'b1, 4'b0100);
      req = 4'b0000;
      repeat (16) tick();
      chk_all("h3.hold_last", S_HOLD, 1'b1, 4'b0000);
      tick();
      chk_all("h3.off", S_OFF, 1'b0, 4'b0000);

      // asynchronous reset mid-ON, then full wake-up with req held
      req = 4'b0101;
      repeat (3) tick();
      chk_all("h4.on", S_ON, 1'b1, 4'b0101);
      #2 CD = 1'b1;
      #1;
      chk_all("h4.async_cd", S_OFF, 1'b0, 4'b0000);
      @(negedge CP);
      CD = 1'b0;
      tick();
      chk_all("h4.wake1", S_WAKE, 1'b1, 4'b0000);
      tick();
      chk_all("h4.wake2", S_WAKE, 1'b1, 4'b0000);
      tick();
      chk_all("h4.ack", S_ON, 1'b1, 4'b0101);
      req = 4'b0000;
      pulse_reset();

`ifdef CLK_GATE_STAT_EN
      check("stat.reset", 32'(stat_cnt), 32'd0);
      req = 4'b0001;
      tick();
      check("stat.first", 32'(stat_cnt), 32'd0);
      repeat (4) tick();
      check("stat.count4", 32'(stat_cnt), 32'd4);
      repeat (20) tick();
      check("stat.saturate", 32'(stat_cnt), 32'd15);
      stat_clr = 1'b1;
      tick();
      check("stat.clear", 32'(stat_cnt), 32'd0);
      stat_clr = 1'b0;
      tick();
      check("stat.resume", 32'(stat_cnt), 32'd1);
      req = 4'b0000;
      pulse_reset();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
